osd_menu_ctrl: RTL and testbench

//  Parametrised OSD menu controller; successor to the fixed H/V-offset OSD control FSM.

---
 rtl/osd_menu_ctrl.sv | 243 ++++++++++++++++++++++++
 tb/tb_osd_menu_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/osd_menu_ctrl.sv
// OSD menu controller: N_ITEMS signed settings with a cursor, edited from pad
// keys with auto-repeat. Each accepted key event redraws the cursor glyphs and
// the "+dd"/"-dd" value text through the shared char RAM write port. The block
// also owns the OSD auto-hide timer.
module osd_menu_ctrl #(
   parameter int N_ITEMS   = 4,
   parameter int VAL_W     = 6,
   parameter int VAL_MAX   = 15,
   parameter int COLS      = 32,
   parameter int ROW0      = 16,
   parameter int CUR_COL   = 1,
   parameter int VAL_COL   = 17,
   parameter int TIMEOUT   = 128000000,
   parameter int RPT_DELAY = 16000000,
   parameter int RPT_RATE  = 3200000
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     key_up,
   input  logic                     key_down,
   input  logic                     key_left,
   input  logic                     key_right,
   input  logic                     key_a,
   output logic                     wr_en,
   output logic [10:0]              wr_addr,
   output logic [7:0]               wr_data,
   output logic [N_ITEMS*VAL_W-1:0] settings,
   output logic [2:0]               cursor,
   output logic                     osd_active,
   output logic                     busy
);

   localparam int NKEY    = 5;
   localparam int K_UP    = 0;
   localparam int K_DOWN  = 1;
   localparam int K_LEFT  = 2;
   localparam int K_RIGHT = 3;
   localparam int K_A     = 4;
   localparam int NWR     = 4 * N_ITEMS;
   localparam int WC_W    = $clog2(NWR + 1);
   localparam int CNT_W   = $clog2(RPT_DELAY + 1);
   localparam int TMR_W   = $clog2(TIMEOUT + 1);

   // A held key fires when its counter reaches RPT_FIRE (the RPT_DELAY-th held
   // cycle, the edge cycle counting as the first); the counter is then pulled
   // back so it fires again RPT_RATE cycles later. Assumes RPT_RATE <= RPT_DELAY.
   localparam logic [CNT_W-1:0] RPT_FIRE   = CNT_W'(RPT_DELAY - 1);
   localparam logic [CNT_W-1:0] RPT_RELOAD = CNT_W'(RPT_DELAY - RPT_RATE);
   localparam logic [TMR_W-1:0] TMR_LOAD   = TMR_W'(TIMEOUT);
   localparam logic [WC_W-1:0]  WR_LAST    = WC_W'(NWR);
   localparam logic [2:0]       CUR_LAST   = 3'(N_ITEMS - 1);
   localparam logic signed [VAL_W-1:0] VMAX = VAL_W'(VAL_MAX);
   localparam logic signed [VAL_W-1:0] VMIN = VAL_W'(-VAL_MAX);

   typedef enum logic [1:0] {INIT, IDLE, APPLY, REFRESH} state_t;

   state_t                   state;
   logic [NKEY-1:0]          keys;
   logic [NKEY-1:0]          key_prev;
   logic [NKEY-1:0]          key_ev;
   logic [NKEY-1:0]          ev_p0;
   logic [CNT_W-1:0]         rpt_cnt [NKEY];
   logic [TMR_W-1:0]         timer;
   logic [WC_W-1:0]          wcnt;
   logic signed [VAL_W-1:0]  val     [N_ITEMS];
   logic signed [VAL_W-1:0]  val_nxt [N_ITEMS];
   logic [2:0]               cursor_nxt;
   logic                     ud_one;
   logic                     lr_one;
   logic [WC_W-1:0]          wsel;
   logic [WC_W-3:0]          wsel_item;
   logic [1:0]               wsel_sub;
   logic signed [VAL_W-1:0]  r_val;
   logic [6:0]               r_mag;
   logic [6:0]               r_tens;
   logic [6:0]               r_units;
   int                       r_col;
   logic [10:0]              r_addr;
   logic [7:0]               r_data;

   // Step a value by one towards +/-VAL_MAX, clamping at the bound.
   function automatic logic signed [VAL_W-1:0] sat_step(input logic signed [VAL_W-1:0] v,
                                                        input logic inc);
      if (inc)
         return (v >= VMAX) ? VMAX : v + VAL_W'(1);
      else
         return (v <= VMIN) ? VMIN : v - VAL_W'(1);
   endfunction

   // Magnitude of a setting, at most 99 so it always fits 7 bits.
   function automatic logic [6:0] mag7(input logic signed [VAL_W-1:0] v);
      logic signed [VAL_W-1:0] a;
      a = (v < VAL_W'(0)) ? -v : v;
      return 7'(a);
   endfunction

   assign keys = {key_a, key_right, key_left, key_down, key_up};

   // Per-key edge history and hold counters for auto-repeat.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         key_prev <= '0;
         for (int k = 0; k < NKEY; k++) rpt_cnt[k] <= '0;
      end else begin
         key_prev <= keys;
         for (int k = 0; k < NKEY; k++) begin
            if (!keys[k])
               rpt_cnt[k] <= '0;
            else if (rpt_cnt[k] == RPT_FIRE)
               rpt_cnt[k] <= RPT_RELOAD;
            else
               rpt_cnt[k] <= rpt_cnt[k] + CNT_W'(1);
         end
      end
   end

   // Key events: rising edge or auto-repeat pulse on a held key.
   always_comb begin
      key_ev = '0;
      for (int k = 0; k < NKEY; k++)
         key_ev[k] = keys[k] & (~key_prev[k] | (rpt_cnt[k] == RPT_FIRE));
   end

   // Next cursor/settings; only APPLY changes them, so they stay frozen
   // (effectively snapshotted) for the whole REFRESH that follows.
   always_comb begin
      cursor_nxt = cursor;
      for (int i = 0; i < N_ITEMS; i++) val_nxt[i] = val[i];
      ud_one = ev_p0[K_UP] ^ ev_p0[K_DOWN];
      lr_one = ev_p0[K_LEFT] ^ ev_p0[K_RIGHT];
      if (state == APPLY) begin
         if (ud_one) begin
            if (ev_p0[K_UP])
               cursor_nxt = (cursor == 3'd0) ? CUR_LAST : cursor - 3'd1;
            else
               cursor_nxt = (cursor == CUR_LAST) ? 3'd0 : cursor + 3'd1;
         end else if (lr_one || ev_p0[K_A]) begin
            for (int i = 0; i < N_ITEMS; i++)
               if (int'(cursor) == i)
                  val_nxt[i] = lr_one ? sat_step(val[i], ev_p0[K_RIGHT]) : '0;
         end
      end
   end

   // Character for the write being issued: 4 per item (cursor, sign, tens, units).
   // On REFRESH entry the write index is 0 and post-APPLY values are used.
   always_comb begin
      wsel      = (state == REFRESH) ? wcnt : '0;
      wsel_item = wsel[WC_W-1:2];
      wsel_sub  = wsel[1:0];
      r_val     = '0;
      for (int i = 0; i < N_ITEMS; i++)
         if (int'(wsel_item) == i) r_val = val_nxt[i];
      r_mag   = mag7(r_val);
      r_tens  = r_mag / 7'd10;
      r_units = r_mag % 7'd10;
      r_col   = CUR_COL;
      r_data  = 8'h20;
      case (wsel_sub)
         2'd0: begin
            r_col  = CUR_COL;
            r_data = (int'(cursor_nxt) == int'(wsel_item)) ? 8'h3E : 8'h20;
         end
         2'd1: begin
            r_col  = VAL_COL;
            r_data = (r_val < VAL_W'(0)) ? 8'h2D : 8'h2B;
         end
         2'd2: begin
            r_col  = VAL_COL + 1;
            r_data = (r_tens == 7'd0) ? 8'h20 : 8'h30 + {1'b0, r_tens};
         end
         default: begin
            r_col  = VAL_COL + 2;
            r_data = 8'h30 + {1'b0, r_units};
         end
      endcase
      r_addr = 11'((ROW0 + int'(wsel_item)) * COLS + r_col);
   end

   // Packed settings bus for the downstream video logic.
   always_comb begin
      settings = '0;
      for (int i = 0; i < N_ITEMS; i++) settings[i*VAL_W +: VAL_W] = val[i];
   end

   // Menu FSM, auto-hide timer and registered char RAM write port.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= INIT;
         ev_p0      <= '0;
         wcnt       <= '0;
         wr_en      <= 1'b0;
         wr_addr    <= '0;
         wr_data    <= '0;
         busy       <= 1'b0;
         cursor     <= '0;
         timer      <= '0;
         osd_active <= 1'b0;
         for (int i = 0; i < N_ITEMS; i++) val[i] <= '0;
      end else begin
         cursor <= cursor_nxt;
         for (int i = 0; i < N_ITEMS; i++) val[i] <= val_nxt[i];
         wr_en <= 1'b0;
         busy  <= 1'b0;
         if (timer != '0) timer <= timer - TMR_W'(1);
         osd_active <= (timer > TMR_W'(1));
         case (state)
            INIT, APPLY: begin
               state   <= REFRESH;
               wr_en   <= 1'b1;
               busy    <= 1'b1;
               wr_addr <= r_addr;
               wr_data <= r_data;
               wcnt    <= WC_W'(1);
            end
            IDLE: begin
               if (|key_ev) begin
                  timer      <= TMR_LOAD;
                  osd_active <= 1'b1;
                  // A key on a hidden OSD only wakes it up.
                  if (osd_active) begin
                     ev_p0 <= key_ev;
                     state <= APPLY;
                  end
               end
            end
            REFRESH: begin
               if (wcnt == WR_LAST) begin
                  state <= IDLE;
               end else begin
                  wr_en   <= 1'b1;
                  busy    <= 1'b1;
                  wr_addr <= r_addr;
                  wr_data <= r_data;
                  wcnt    <= wcnt + WC_W'(1);
               end
            end
            default: state <= INIT;
         endcase
      end
   end

endmodule

// File: tb/tb_osd_menu_ctrl.sv
// Bench for osd_menu_ctrl: a reference model pushes every expected char RAM
// write to a queue as keys are driven; a monitor pops and compares writes.
module tb_osd_menu_ctrl;

   localparam int N_ITEMS   = 4;
   localparam int VAL_W     = 6;
   localparam int VAL_MAX   = 15;
   localparam int TIMEOUT   = 300;
   localparam int RPT_DELAY = 40;
   localparam int RPT_RATE  = 20;

   localparam logic [4:0] KU   = 5'b00001;
   localparam logic [4:0] KD   = 5'b00010;
   localparam logic [4:0] KL   = 5'b00100;
   localparam logic [4:0] KR   = 5'b01000;
   localparam logic [4:0] KA   = 5'b10000;
   localparam logic [4:0] KLR  = 5'b01100;
   localparam logic [4:0] KUD  = 5'b00011;
   localparam logic [4:0] KUDR = 5'b01011;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic key_up = 1'b0, key_down = 1'b0, key_left = 1'b0, key_right = 1'b0, key_a = 1'b0;
   logic                     wr_en;
   logic [10:0]              wr_addr;
   logic [7:0]               wr_data;
   logic [N_ITEMS*VAL_W-1:0] settings;
   logic [2:0]               cursor;
   logic                     osd_active;
   logic                     busy;

   osd_menu_ctrl #(
      .N_ITEMS(N_ITEMS), .VAL_W(VAL_W), .VAL_MAX(VAL_MAX), .COLS(32), .ROW0(16),
      .CUR_COL(1), .VAL_COL(17), .TIMEOUT(TIMEOUT), .RPT_DELAY(RPT_DELAY), .RPT_RATE(RPT_RATE)
   ) dut (
      .clk(clk), .reset(reset),
      .key_up(key_up), .key_down(key_down), .key_left(key_left),
      .key_right(key_right), .key_a(key_a),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .settings(settings), .cursor(cursor), .osd_active(osd_active), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [10:0] addr;
      logic [7:0]  data;
   } wr_t;

   typedef struct {
      logic [4:0] keys;
      int         exp_cur;
      int         exp_val;
   } vec_t;

   wr_t         exp_q[$];
   vec_t        vtab[14];
   int          mval[N_ITEMS];
   int          mcur;
   bit          mact;
   logic [10:0] wlog_addr[16];
   logic [7:0]  wlog_data[16];
   int          wpos = 0;
   int          errors = 0;
   int          checks = 0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic push_refresh();
      wr_t w;
      int  a;
      for (int i = 0; i < N_ITEMS; i++) begin
         a = (mval[i] < 0) ? -mval[i] : mval[i];
         w.addr = 11'((16 + i) * 32 + 1);
         w.data = (i == mcur) ? 8'h3E : 8'h20;
         exp_q.push_back(w);
         w.addr = 11'((16 + i) * 32 + 17);
         w.data = (mval[i] < 0) ? 8'h2D : 8'h2B;
         exp_q.push_back(w);
         w.addr = 11'((16 + i) * 32 + 18);
         w.data = (a >= 10) ? 8'(48 + a / 10) : 8'h20;
         exp_q.push_back(w);
         w.addr = 11'((16 + i) * 32 + 19);
         w.data = 8'(48 + a % 10);
         exp_q.push_back(w);
      end
   endtask

   task automatic model_event(input logic [4:0] k);
      if (!mact) begin
         mact = 1'b1;
      end else begin
         if (k[0] ^ k[1]) begin
            if (k[0]) mcur = (mcur + N_ITEMS - 1) % N_ITEMS;
            else      mcur = (mcur + 1) % N_ITEMS;
         end else if (k[2] ^ k[3]) begin
            if (k[3]) mval[mcur] = (mval[mcur] >= VAL_MAX) ? VAL_MAX : mval[mcur] + 1;
            else      mval[mcur] = (mval[mcur] <= -VAL_MAX) ? -VAL_MAX : mval[mcur] - 1;
         end else if (k[4]) begin
            mval[mcur] = 0;
         end
         push_refresh();
      end
   endtask

   function automatic int model_pack();
      logic [N_ITEMS*VAL_W-1:0] p;
      p = '0;
      for (int i = 0; i < N_ITEMS; i++) p[i*VAL_W +: VAL_W] = VAL_W'(mval[i]);
      return int'(p);
   endfunction

   function automatic int dut_val(input int i);
      return int'($signed(settings[i*VAL_W +: VAL_W]));
   endfunction

   task automatic drive(input logic [4:0] k);
      {key_a, key_right, key_left, key_down, key_up} = k;
   endtask

   task automatic wait_refresh();
      int n;
      n = 0;
      while (!busy && n < 10) begin @(negedge clk); n++; end
      check("refresh_start", int'(busy), 1);
      n = 0;
      while (busy && n < 40) begin @(negedge clk); n++; end
      check("refresh_end", int'(busy), 0);
   endtask

   // One-cycle key pulse applied while the controller is idle.
   task automatic press(input logic [4:0] k);
      bit was_act;
      int n;
      was_act = mact;
      @(negedge clk);
      drive(k);
      model_event(k);
      @(negedge clk);
      drive(5'd0);
      if (was_act) begin
         @(negedge clk);
         check("latency_wr_en", int'(wr_en), 1);
         n = 0;
         while (busy && n < 40) begin @(negedge clk); n++; end
         check("refresh_end", int'(busy), 0);
      end else begin
         repeat (3) @(negedge clk);
         check("wake_active", int'(osd_active), 1);
      end
      @(negedge clk);
      check("sb_drained", exp_q.size(), 0);
   endtask

   // Write monitor: every strobe must match the next expected write.
   always @(negedge clk) begin
      wr_t w;
      if (wr_en) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected: write addr=%0d data=%0h, none required", wr_addr, wr_data);
         end else begin
            w = exp_q.pop_front();
            check("sb_addr", int'(wr_addr), int'(w.addr));
            check("sb_data", int'(wr_data), int'(w.data));
         end
         wlog_addr[wpos] = wr_addr;
         wlog_data[wpos] = wr_data;
         wpos = (wpos + 1) % 16;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt;

      vtab[0]  = '{KR,   0,  1};
      vtab[1]  = '{KR,   0,  2};
      vtab[2]  = '{KL,   0,  1};
      vtab[3]  = '{KD,   1,  0};
      vtab[4]  = '{KR,   1,  1};
      vtab[5]  = '{KLR,  1,  1};
      vtab[6]  = '{KUD,  1,  1};
      vtab[7]  = '{KUDR, 1,  2};
      vtab[8]  = '{KA,   1,  0};
      vtab[9]  = '{KU,   0,  1};
      vtab[10] = '{KU,   3,  0};
      vtab[11] = '{KL,   3, -1};
      vtab[12] = '{KD,   0,  1};
      vtab[13] = '{KA,   0,  0};

      for (int i = 0; i < N_ITEMS; i++) mval[i] = 0;
      mcur = 0;
      mact = 1'b0;
      drive(5'd0);
      reset = 1'b1;
      repeat (3) @(negedge clk);

      // Reset state
      check("rst_wr_en", int'(wr_en), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_osd_active", int'(osd_active), 0);
      check("rst_settings", int'(settings), 0);
      check("rst_cursor", int'(cursor), 0);

      // Power-up refresh
      push_refresh();
      reset = 1'b0;
      wait_refresh();
      @(negedge clk);
      check("init_drained", exp_q.size(), 0);
      check("init_addr0", int'(wlog_addr[0]), 513);
      check("init_cur0", int'(wlog_data[0]), 8'h3E);
      check("init_sign0", int'(wlog_data[1]), 8'h2B);
      check("init_addr1", int'(wlog_addr[1]), 529);
      check("init_tens0", int'(wlog_data[2]), 8'h20);
      check("init_units0", int'(wlog_data[3]), 8'h30);
      check("init_addr3", int'(wlog_addr[3]), 531);
      check("init_cur1", int'(wlog_data[4]), 8'h20);
      check("init_addr4", int'(wlog_addr[4]), 545);
      check("init_cur3", int'(wlog_data[12]), 8'h20);
      check("init_osd_off", int'(osd_active), 0);

      // Wake: first key only shows the OSD
      press(KR);
      check("wake_settings", int'(settings), 0);
      check("wake_cursor", int'(cursor), 0);

      // Table-driven key sequence
      for (int v = 0; v < 14; v++) begin
         press(vtab[v].keys);
         check("tab_cursor", int'(cursor), vtab[v].exp_cur);
         check("tab_value", dut_val(vtab[v].exp_cur), vtab[v].exp_val);
         check("tab_settings", int'(settings), model_pack());
      end

      // Saturation at -VAL_MAX on item 0
      for (int n = 0; n < 16; n++) press(KL);
      check("sat_value", dut_val(0), -15);
      check("sat_sign", int'(wlog_data[1]), 8'h2D);
      check("sat_tens", int'(wlog_data[2]), 8'h31);
      check("sat_units", int'(wlog_data[3]), 8'h35);

      // Held key: edge plus three auto-repeats
      @(negedge clk);
      drive(KR);
      repeat (4) model_event(KR);
      repeat (RPT_DELAY + 2 * RPT_RATE) @(negedge clk);
      drive(5'd0);
      wait_refresh();
      @(negedge clk);
      check("hold_drained", exp_q.size(), 0);
      check("hold_value", dut_val(0), -11);

      // Cursor wrap from item 0 upwards
      press(KU);
      check("wrap_cursor", int'(cursor), 3);
      check("wrap_row16", int'(wlog_data[0]), 8'h20);
      check("wrap_row16_addr", int'(wlog_addr[0]), 513);
      check("wrap_row19", int'(wlog_data[12]), 8'h3E);
      check("wrap_row19_addr", int'(wlog_addr[12]), 609);
      press(KD);
      check("wrap_back", int'(cursor), 0);

      // Auto-hide: visible for exactly TIMEOUT cycles after the last event
      @(negedge clk);
      drive(KR);
      model_event(KR);
      @(negedge clk);
      drive(5'd0);
      cnt = 0;
      while (osd_active && cnt < TIMEOUT + 50) begin
         cnt++;
         @(negedge clk);
      end
      check("timeout_len", cnt, TIMEOUT);
      mact = 1'b0;
      check("timeout_off", int'(osd_active), 0);
      check("timeout_drained", exp_q.size(), 0);

      // Reset in the middle of a refresh
      press(KR);
      @(negedge clk);
      drive(KR);
      model_event(KR);
      @(negedge clk);
      drive(5'd0);
      repeat (6) @(negedge clk);
      check("mid_busy", int'(busy), 1);
      @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      check("abort_wr_en", int'(wr_en), 0);
      check("abort_busy", int'(busy), 0);
      exp_q.delete();
      wpos = 0;
      for (int i = 0; i < N_ITEMS; i++) mval[i] = 0;
      mcur = 0;
      mact = 1'b0;
      push_refresh();
      repeat (2) @(negedge clk);
      reset = 1'b0;
      wait_refresh();
      @(negedge clk);
      check("rerun_drained", exp_q.size(), 0);
      check("rerun_settings", int'(settings), 0);
      check("rerun_osd_off", int'(osd_active), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
